// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences the MEM stage's one-cycle load/store request
// into a fixed-latency access on the single-port data memory. It stalls the
// pipeline until the access completes and registers load data for MEM/WB.
// Optional feature macro: DMEM_LOADER_PORT_EN adds a program/data loader port
// that shares the memory at lower priority than the pipeline.
module dmem_access_ctrl #(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_read,
    input  logic        p_write,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_wdata,
    output logic [31:0] p_rdata,
    output logic        stall,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_read,
    output logic        m_write,
`ifdef DMEM_LOADER_PORT_EN
    input  logic        l_req,
    input  logic        l_we,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_gnt,
    output logic        l_done,
    output logic [31:0] l_rdata,
`endif
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        P_ACC,
        P_DONE
`ifdef DMEM_LOADER_PORT_EN
        ,
        L_ACC
`endif
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             p_req;
    logic             take_p;
    logic             in_acc;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic             acc_rd;
    logic             acc_wr;
`ifdef DMEM_LOADER_PORT_EN
    logic             take_l;
    logic [31:0]      l_rdata_q;
`endif

    assign p_req    = p_read | p_write;
    assign cnt_zero = (cnt == '0);

`ifdef DMEM_LOADER_PORT_EN
    assign in_acc = (state == P_ACC) || (state == L_ACC);
`else
    assign in_acc = (state == P_ACC);
`endif

    // Stall is combinational so the pipeline freezes in the very cycle the
    // request shows up; only the release cycle lets the instruction leave.
    assign stall   = p_req & (state != P_DONE);

    // Memory strobes come from the state register, so an asynchronous reset
    // removes them at once and an unfinished write is simply abandoned.
    assign m_read  = in_acc & acc_rd;
    assign m_write = in_acc & acc_wr;
    assign m_addr  = acc_addr;
    assign m_wdata = acc_wdata;

`ifdef DMEM_LOADER_PORT_EN
    // Grant only from IDLE with no pipeline request; held low during reset.
    assign l_gnt   = ~rst & (state == IDLE) & ~p_req & l_req;
    assign l_done  = (state == L_ACC) & cnt_zero;
    assign l_rdata = (l_done & acc_rd) ? m_rdata : l_rdata_q;
`endif

    // Next-state logic: pipeline first, then loader; release cycle always idles.
    always_comb begin
        next_state = state;
        take_p     = 1'b0;
`ifdef DMEM_LOADER_PORT_EN
        take_l     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (p_req) begin
                    next_state = P_ACC;
                    take_p     = 1'b1;
                end
`ifdef DMEM_LOADER_PORT_EN
                else if (l_req) begin
                    next_state = L_ACC;
                    take_l     = 1'b1;
                end
`endif
            end
            P_ACC: begin
                if (cnt_zero) next_state = P_DONE;
            end
            P_DONE: begin
                next_state = IDLE;
            end
`ifdef DMEM_LOADER_PORT_EN
            L_ACC: begin
                if (cnt_zero) next_state = IDLE;
            end
`endif
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Latch the winning request and run the latency counter down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            acc_addr  <= '0;
            acc_wdata <= '0;
            acc_rd    <= 1'b0;
            acc_wr    <= 1'b0;
        end else if (take_p) begin
            cnt       <= CNT_LOAD;
            acc_addr  <= p_addr;
            acc_wdata <= p_wdata;
            acc_wr    <= p_write;
            acc_rd    <= p_read & ~p_write;
        end
`ifdef DMEM_LOADER_PORT_EN
        else if (take_l) begin
            cnt       <= CNT_LOAD;
            acc_addr  <= l_addr;
            acc_wdata <= l_wdata;
            acc_wr    <= l_we;
            acc_rd    <= ~l_we;
        end
`endif
        else if (in_acc && !cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Capture pipeline load data on the final access cycle; hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        p_rdata <= '0;
        else if ((state == P_ACC) && cnt_zero && acc_rd) p_rdata <= m_rdata;
    end

`ifdef DMEM_LOADER_PORT_EN
    // Keep the last loader read value after the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         l_rdata_q <= '0;
        else if ((state == L_ACC) && cnt_zero && acc_rd) l_rdata_q <= m_rdata;
    end
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: scoreboard bench for dmem_access_ctrl. A fixed-latency
// memory model serves the DUT; a reference memory predicts every load result.
module tb_dmem_access_ctrl;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        p_read;
    logic        p_write;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic [31:0] p_rdata;
    logic        stall;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_rdata;
`ifdef DMEM_LOADER_PORT_EN
    logic        l_req;
    logic        l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_gnt;
    logic        l_done;
    logic [31:0] l_rdata;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int addr_err = 0;
    int last_req_cyc = 0;
    int last_rel_cyc = 0;

    logic [31:0] seed_mem [64];
    logic [31:0] dev_mem  [64];
    logic [31:0] ref_mem  [64];
    logic        mem_ready = 1'b0;
    int          wr_run = 0;
    logic [31:0] last_rd;

    typedef struct {
        bit          rd;
        logic [31:0] data;
    } lexp_t;

    logic [31:0] p_exp [$];
    lexp_t       l_exp [$];

    dmem_access_ctrl #(.LATENCY(LAT), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .p_read  (p_read),
        .p_write (p_write),
        .p_addr  (p_addr),
        .p_wdata (p_wdata),
        .p_rdata (p_rdata),
        .stall   (stall),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_read  (m_read),
        .m_write (m_write),
`ifdef DMEM_LOADER_PORT_EN
        .l_req   (l_req),
        .l_we    (l_we),
        .l_addr  (l_addr),
        .l_wdata (l_wdata),
        .l_gnt   (l_gnt),
        .l_done  (l_done),
        .l_rdata (l_rdata),
`endif
        .m_rdata (m_rdata)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used for timing checks.
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: a write commits only after LAT consecutive write cycles.
    assign m_rdata = dev_mem[m_addr[7:2]];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) dev_mem[i] <= seed_mem[i];
            mem_ready <= 1'b1;
        end else if (rst || !m_write) begin
            wr_run <= 0;
        end else if (wr_run == LAT - 1) begin
            dev_mem[m_addr[7:2]] <= m_wdata;
            wr_run <= 0;
        end else begin
            wr_run <= wr_run + 1;
        end
        if ((m_read || m_write) && ((m_addr[31:8] != 24'h0) || (m_addr[1:0] != 2'b00)))
            addr_err <= addr_err + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, actual, expected);
        end
    endtask

    // Pipeline monitor: on every release cycle compare the registered load data.
    always @(negedge clk) begin
        if (!rst && (p_read || p_write) && !stall) begin
            checkOutput("p_queue", 32'(p_exp.size() > 0), 32'd1);
            if (p_exp.size() > 0) checkOutput("p_rdata", p_rdata, p_exp.pop_front());
        end
    end

`ifdef DMEM_LOADER_PORT_EN
    // Loader monitor: compare read data while the done pulse is high.
    always @(negedge clk) begin
        lexp_t le;
        if (!rst && l_done) begin
            checkOutput("l_queue", 32'(l_exp.size() > 0), 32'd1);
            if (l_exp.size() > 0) begin
                le = l_exp.pop_front();
                if (le.rd) checkOutput("l_rdata", l_rdata, le.data);
            end
        end
    end
`endif

    // Issue one pipeline access, predict its p_rdata and measure stall/strobe cycles.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int exp_stall,
                                 input int exp_act, input bit chain);
        int st = 0;
        int act = 0;
        bit done = 0;
        if (wr) begin
            ref_mem[addr[7:2]] = wdata;
            p_exp.push_back(last_rd);
        end else begin
            last_rd = ref_mem[addr[7:2]];
            p_exp.push_back(last_rd);
        end
        @(posedge clk); #1;
        p_read = rd; p_write = wr; p_addr = addr; p_wdata = wdata;
        last_req_cyc = cyc;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (m_read || m_write) act++;
            if (stall) st++;
            else begin
                done = 1;
                last_rel_cyc = cyc;
            end
        end
        checkOutput("p_release_seen", 32'(done), 32'd1);
        checkOutput("stall_cycles", st, exp_stall);
        checkOutput("mem_strobe_cycles", act, exp_act);
        if (!chain) begin
            @(posedge clk); #1;
            p_read = 1'b0; p_write = 1'b0;
        end
    endtask

`ifdef DMEM_LOADER_PORT_EN
    // Issue one loader access and check the grant-to-done distance.
    task automatic applyLoader(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, output int gnt_c);
        bit got = 0;
        int done_c = 0;
        lexp_t le;
        le.rd = !we;
        le.data = ref_mem[addr[7:2]];
        if (we) ref_mem[addr[7:2]] = wdata;
        l_exp.push_back(le);
        gnt_c = 0;
        @(posedge clk); #1;
        l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wdata;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (l_gnt) begin
                got = 1;
                gnt_c = cyc;
            end
        end
        checkOutput("l_gnt_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        l_req = 1'b0;
        got = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (l_done) begin
                got = 1;
                done_c = cyc;
            end
        end
        checkOutput("l_done_seen", 32'(got), 32'd1);
        checkOutput("l_done_delay", done_c - gnt_c, LAT);
    endtask
`endif

    // Safety net so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        int t0;
        int r;
        logic [31:0] a;
`ifdef DMEM_LOADER_PORT_EN
        int g0;
        int g1;
`endif
        for (int i = 0; i < 64; i++) seed_mem[i] = $urandom;
        seed_mem[4] = 32'hDEADBEEF;
        for (int i = 0; i < 64; i++) ref_mem[i] = seed_mem[i];
        last_rd = '0;

        rst = 1'b1; p_read = 1'b0; p_write = 1'b0; p_addr = '0; p_wdata = '0;
`ifdef DMEM_LOADER_PORT_EN
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
`endif
        repeat (3) @(negedge clk);
        checkOutput("rst_p_rdata", p_rdata, 32'h0);
        checkOutput("rst_m_read", 32'(m_read), 32'd0);
        checkOutput("rst_m_write", 32'(m_write), 32'd0);
        checkOutput("rst_m_addr", m_addr, 32'h0);
        checkOutput("rst_m_wdata", m_wdata, 32'h0);
        checkOutput("rst_stall_idle", 32'(stall), 32'd0);
        p_read = 1'b1; #1;
        checkOutput("rst_stall_formula", 32'(stall), 32'd1);
        p_read = 1'b0;
`ifdef DMEM_LOADER_PORT_EN
        checkOutput("rst_l_gnt", 32'(l_gnt), 32'd0);
        checkOutput("rst_l_done", 32'(l_done), 32'd0);
        checkOutput("rst_l_rdata", l_rdata, 32'h0);
`endif
        @(negedge clk); rst = 1'b0;
        $display("[TB] reset released");

        // Directed: load, store, readback, store with both strobes.
        applyStimulus(1, 0, 32'h10, 32'h0, LAT + 1, LAT, 0);
        applyStimulus(0, 1, 32'h20, 32'h12345678, LAT + 1, LAT, 0);
        applyStimulus(1, 0, 32'h20, 32'h0, LAT + 1, LAT, 0);
        applyStimulus(1, 1, 32'h24, 32'hCAFEF00D, LAT + 1, LAT, 0);
        applyStimulus(1, 0, 32'h24, 32'h0, LAT + 1, LAT, 0);

        // Back-to-back loads keep LAT+2 cycle spacing.
        applyStimulus(1, 0, 32'h10, 32'h0, LAT + 1, LAT, 1);
        t0 = last_req_cyc;
        applyStimulus(1, 0, 32'h14, 32'h0, LAT + 1, LAT, 1);
        applyStimulus(1, 0, 32'h18, 32'h0, LAT + 1, LAT, 1);
        applyStimulus(1, 0, 32'h1C, 32'h0, LAT + 1, LAT, 0);
        checkOutput("b2b_cycles", last_rel_cyc - t0 + 1, 4 * (LAT + 2));

        // Randomized pipeline traffic.
        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 3);
            a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            applyStimulus(r != 2, r >= 2, a, $urandom, LAT + 1, LAT, 1'($urandom_range(0, 1)));
        end
        @(posedge clk); #1;
        p_read = 1'b0; p_write = 1'b0;

`ifdef DMEM_LOADER_PORT_EN
        // Simultaneous requests: pipeline first, loader granted after release.
        fork
            applyStimulus(1, 0, 32'h40, 32'h0, LAT + 1, LAT, 0);
            applyLoader(0, 32'h44, 32'h0, g0);
        join
        checkOutput("l_gnt_after_release", g0 - last_rel_cyc, 1);

        // Pipeline read arriving during a loader write waits and sees its data.
        fork
            applyLoader(1, 32'h48, 32'hA5A55A5A, g1);
            begin
                for (int i = 0; i < 64; i++) begin
                    @(negedge clk);
                    if (l_gnt) break;
                end
                applyStimulus(1, 0, 32'h48, 32'h0, 2 * LAT + 1, 2 * LAT, 0);
            end
        join
        applyLoader(0, 32'h48, 32'h0, g1);
`endif

        // Reset in the middle of a pipeline read.
        applyStimulus(1, 0, 32'h10, 32'h0, LAT + 1, LAT, 0);
        @(posedge clk); #1;
        p_read = 1'b1; p_addr = 32'h30;
        @(posedge clk); #1;
        checkOutput("mid_m_read", 32'(m_read), 32'd1);
        #2;
        p_read = 1'b0; rst = 1'b1;
        #1;
        checkOutput("async_m_read", 32'(m_read), 32'd0);
        checkOutput("async_m_write", 32'(m_write), 32'd0);
        checkOutput("async_stall", 32'(stall), 32'd0);
        checkOutput("async_p_rdata", p_rdata, 32'h0);
        last_rd = '0;
        @(negedge clk); rst = 1'b0;
        applyStimulus(0, 1, 32'h34, 32'h0BADC0DE, LAT + 1, LAT, 0);
        applyStimulus(1, 0, 32'h34, 32'h0, LAT + 1, LAT, 0);

        repeat (3) @(negedge clk);
        checkOutput("p_queue_left", p_exp.size(), 0);
`ifdef DMEM_LOADER_PORT_EN
        checkOutput("l_queue_left", l_exp.size(), 0);
`endif
        checkOutput("addr_range", addr_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
